// File: rtl/parity_frame_rx_pkg.sv
// ---------------------------------------------------------------------------
// parity_rx_pkg
// Shared definitions for the byte-plus-parity serial link.
//   rx_state_t  : receiver FSM states (IDLE, DATA, PARITY, STOP)
//   ERR_CNT_W   : width of the optional error counter
//   calc_parity : expected parity bit for a data word. The transmit side
//                 uses the same function, so both ends agree on the rule.
// ---------------------------------------------------------------------------
package parity_rx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_t;

    localparam int ERR_CNT_W = 8;

    // Even mode gives the XOR-reduction of the data. Odd mode gives its
    // complement. Words narrower than 16 bits are zero-extended by the
    // caller, and zero-extension does not change the XOR result.
    function automatic logic calc_parity(input logic [15:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/parity_frame_rx_if.sv
// ---------------------------------------------------------------------------
// parity_frame_rx_if
// Bundles the strobe, the serial line and the deframed results of the
// receiver.
//   en, serial_in                         : bit strobe and serial line
//   data_out, valid, parity_err,
//   frame_err, busy                       : recovered word and its status
//   err_count                             : present only with PARITY_RX_ERR_CNT_EN
// Modports:
//   master : drives the line and observes the results (upstream / bench)
//   slave  : the receiver itself
// ---------------------------------------------------------------------------
interface parity_frame_rx_if
    import parity_rx_pkg::*;
#(
    parameter int DATA_W = 8
);
    logic              en;
    logic              serial_in;
    logic [DATA_W-1:0] data_out;
    logic              valid;
    logic              parity_err;
    logic              frame_err;
    logic              busy;
`ifdef PARITY_RX_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_count;
`endif

`ifdef PARITY_RX_ERR_CNT_EN
    modport master (output en, serial_in,
                    input  data_out, valid, parity_err, frame_err, busy, err_count);
    modport slave  (input  en, serial_in,
                    output data_out, valid, parity_err, frame_err, busy, err_count);
`else
    modport master (output en, serial_in,
                    input  data_out, valid, parity_err, frame_err, busy);
    modport slave  (input  en, serial_in,
                    output data_out, valid, parity_err, frame_err, busy);
`endif

endinterface

// File: rtl/parity_frame_rx_shift.sv
// ---------------------------------------------------------------------------
// parity_rx_shift
// DATA_W-bit right-shift register. New bits enter at the MSB, so after
// DATA_W shifts the first bit received sits in bit 0. This matches an
// LSB-first line.
//   clk, reset : clock and synchronous active-high reset
//   shift_en   : shift one bit on this cycle
//   serial_in  : bit shifted in at the MSB
//   q          : register contents
// ---------------------------------------------------------------------------
module parity_rx_shift #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              shift_en,
    input  logic              serial_in,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] r_shiftReg;

    // Shift right on each enabled cycle. Otherwise hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shiftReg <= '0;
        end else if (shift_en) begin
            r_shiftReg <= {serial_in, r_shiftReg[DATA_W-1:1]};
        end
    end

    assign q = r_shiftReg;

endmodule

// File: rtl/parity_frame_rx.sv
// ---------------------------------------------------------------------------
// parity_frame_rx
// Serial receiver for start / DATA_W data bits (LSB first) / parity / stop
// frames. The line is sampled only on cycles with en=1. Each completed
// frame gives a one-cycle valid pulse. data_out and the error flags hold
// until the next frame completes.
//   clk    : system clock, rising edge
//   reset  : synchronous active-high reset, highest priority
//   rxIf   : parity_frame_rx_if.slave
//            (en, serial_in -> data_out, valid, parity_err, frame_err,
//             busy, and err_count when enabled)
// Optional feature macro: PARITY_RX_ERR_CNT_EN. When defined, it adds a
// saturating count of frames that had any error.
// ---------------------------------------------------------------------------
module parity_frame_rx
    import parity_rx_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    parity_frame_rx_if.slave rxIf
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    rx_state_t         r_state;
    rx_state_t         w_nextState;
    logic [CNT_W-1:0]  r_bitCnt;
    logic              r_parityBit;
    logic [DATA_W-1:0] r_dataOut;
    logic              r_valid;
    logic              r_parityErr;
    logic              r_frameErr;
    logic [DATA_W-1:0] w_shiftQ;
    logic              w_shiftEn;
    logic              w_frameDone;
    logic              w_parityErr;
    logic              w_busy;

    parity_rx_shift #(.DATA_W(DATA_W)) u_shift (
        .clk       (clk),
        .reset     (reset),
        .shift_en  (w_shiftEn),
        .serial_in (rxIf.serial_in),
        .q         (w_shiftQ)
    );

    // State register. The state moves only through w_nextState, and
    // w_nextState changes only on strobe cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. A low line in IDLE is a start bit. DATA leaves
    // after the bit sampled with the counter at its last value.
    always_comb begin
        w_nextState = r_state;
        if (rxIf.en) begin
            case (r_state)
                IDLE:    if (!rxIf.serial_in) w_nextState = DATA;
                DATA:    if (r_bitCnt == LAST_BIT) w_nextState = PARITY;
                PARITY:  w_nextState = STOP;
                STOP:    w_nextState = IDLE;
                default: w_nextState = IDLE;
            endcase
        end
    end

    // Decoded controls. busy is derived from the registered state, so it
    // rises the cycle after the start bit and falls once STOP is left.
    always_comb begin
        w_busy      = (r_state != IDLE);
        w_shiftEn   = rxIf.en && (r_state == DATA);
        w_frameDone = rxIf.en && (r_state == STOP);
        w_parityErr = (r_parityBit != calc_parity(16'(w_shiftQ), ODD_PARITY));
    end

    // Bit counter. It clears on every strobe in IDLE and stops at the last
    // bit, so it never wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bitCnt <= '0;
        end else if (rxIf.en) begin
            if (r_state == IDLE) begin
                r_bitCnt <= '0;
            end else if (r_state == DATA && r_bitCnt != LAST_BIT) begin
                r_bitCnt <= r_bitCnt + 1'b1;
            end
        end
    end

    // Parity bit capture. It is held until STOP compares it with the data.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_parityBit <= 1'b0;
        end else if (rxIf.en && r_state == PARITY) begin
            r_parityBit <= rxIf.serial_in;
        end
    end

    // Result registers. They load on the stop-bit strobe. Frames with
    // errors are still delivered, and the flags qualify them. valid is
    // a single-cycle pulse whatever the strobe does next.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dataOut   <= '0;
            r_valid     <= 1'b0;
            r_parityErr <= 1'b0;
            r_frameErr  <= 1'b0;
        end else begin
            r_valid <= w_frameDone;
            if (w_frameDone) begin
                r_dataOut   <= w_shiftQ;
                r_parityErr <= w_parityErr;
                r_frameErr  <= ~rxIf.serial_in;
            end
        end
    end

`ifdef PARITY_RX_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] r_errCount;

    // Error counter. A frame with both errors counts once. The count
    // sticks at all-ones instead of wrapping back to zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_errCount <= '0;
        end else if (w_frameDone && (w_parityErr || !rxIf.serial_in)
                     && r_errCount != {ERR_CNT_W{1'b1}}) begin
            r_errCount <= r_errCount + 1'b1;
        end
    end

    assign rxIf.err_count = r_errCount;
`endif

    assign rxIf.data_out   = r_dataOut;
    assign rxIf.valid      = r_valid;
    assign rxIf.parity_err = r_parityErr;
    assign rxIf.frame_err  = r_frameErr;
    assign rxIf.busy       = w_busy;

endmodule

// File: tb/tb_parity_frame_rx.sv
// ---------------------------------------------------------------------------
// tb_parity_frame_rx
// Directed bench for parity_frame_rx. The same serial stream drives an
// even-parity instance and an odd-parity instance. A table of frames gives
// the expected word and flags for each. Hand-written sequences cover reset
// mid-frame, back-to-back frames and, with PARITY_RX_ERR_CNT_EN, counter
// saturation.
// ---------------------------------------------------------------------------
module tb_parity_frame_rx;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    parity_frame_rx_if #(.DATA_W(8)) evenIf ();
    parity_frame_rx_if #(.DATA_W(8)) oddIf ();

    assign oddIf.en        = evenIf.en;
    assign oddIf.serial_in = evenIf.serial_in;

    parity_frame_rx #(.DATA_W(8), .ODD_PARITY(1'b0)) dutEven (
        .clk   (clk),
        .reset (reset),
        .rxIf  (evenIf)
    );

    parity_frame_rx #(.DATA_W(8), .ODD_PARITY(1'b1)) dutOdd (
        .clk   (clk),
        .reset (reset),
        .rxIf  (oddIf)
    );

    typedef struct {
        logic [7:0] data;
        logic       parityBit;
        logic       stopBit;
        int         enPeriod;
        logic       expParityErrEven;
        logic       expParityErrOdd;
        logic       expFrameErr;
    } vector_t;

    int checks    = 0;
    int errors    = 0;
    int validCnt  = 0;
    int cycle     = 0;

    // Count clock edges so the bench can measure the spacing of valid pulses.
    always @(posedge clk) cycle++;

    // Count every cycle that valid is high. A pulse longer than one cycle
    // shows up as an extra count.
    always @(negedge clk) if (evenIf.valid) validCnt++;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // One strobe. With a period above 1, the line toggles on the idle cycles
    // before the strobe so that any sampling off the strobe shows up.
    task automatic strobe(input logic b, input int period);
        for (int k = 0; k < period - 1; k++) begin
            evenIf.en        = 1'b0;
            evenIf.serial_in = ~evenIf.serial_in;
            @(posedge clk); #1;
        end
        evenIf.en        = 1'b1;
        evenIf.serial_in = b;
        @(posedge clk); #1;
        evenIf.en        = 1'b0;
        evenIf.serial_in = 1'b1;
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic pbit,
                                 input logic stopBit, input int period);
        strobe(1'b0, period);
        for (int i = 0; i < 8; i++) strobe(data[i], period);
        strobe(pbit, period);
        strobe(stopBit, period);
    endtask

    vector_t vecs[6];
    int      v0;
    int      c1;
    int      c2;

    initial begin
        vecs[0] = '{8'hA5, 1'b0, 1'b1, 1, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{8'h07, 1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'h3C, 1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b1};
        vecs[3] = '{8'h5A, 1'b0, 1'b1, 4, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{8'h01, 1'b0, 1'b0, 2, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{8'hE3, 1'b1, 1'b1, 3, 1'b0, 1'b1, 1'b0};

        reset            = 1'b1;
        evenIf.en        = 1'b0;
        evenIf.serial_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_data", 32'(evenIf.data_out), 32'h0);
        checkOutput("rst_valid", 32'(evenIf.valid), 32'h0);
        checkOutput("rst_perr", 32'(evenIf.parity_err), 32'h0);
        checkOutput("rst_ferr", 32'(evenIf.frame_err), 32'h0);
        checkOutput("rst_busy", 32'(evenIf.busy), 32'h0);
`ifdef PARITY_RX_ERR_CNT_EN
        checkOutput("rst_errcnt", 32'(evenIf.err_count), 32'h0);
`endif
        reset = 1'b0;
        @(posedge clk); #1;

        for (int n = 0; n < 6; n++) begin
            v0 = validCnt;
            applyStimulus(vecs[n].data, vecs[n].parityBit, vecs[n].stopBit, vecs[n].enPeriod);
            checkOutput($sformatf("v%0d_valid", n), 32'(evenIf.valid), 32'h1);
            checkOutput($sformatf("v%0d_data", n), 32'(evenIf.data_out), 32'(vecs[n].data));
            checkOutput($sformatf("v%0d_perr_even", n), 32'(evenIf.parity_err),
                        32'(vecs[n].expParityErrEven));
            checkOutput($sformatf("v%0d_perr_odd", n), 32'(oddIf.parity_err),
                        32'(vecs[n].expParityErrOdd));
            checkOutput($sformatf("v%0d_ferr", n), 32'(evenIf.frame_err),
                        32'(vecs[n].expFrameErr));
            checkOutput($sformatf("v%0d_busy", n), 32'(evenIf.busy), 32'h0);
            @(posedge clk); #1;
            checkOutput($sformatf("v%0d_valid_low", n), 32'(evenIf.valid), 32'h0);
            checkOutput($sformatf("v%0d_data_hold", n), 32'(evenIf.data_out), 32'(vecs[n].data));
            checkOutput($sformatf("v%0d_pulses", n), 32'(validCnt - v0), 32'h1);
        end

        // Abort a frame of 0xFF after four data bits.
        v0 = validCnt;
        strobe(1'b0, 1);
        for (int i = 0; i < 4; i++) strobe(1'b1, 1);
        checkOutput("abort_busy_mid", 32'(evenIf.busy), 32'h1);
        reset = 1'b1;
        @(posedge clk); #1;
        checkOutput("abort_data", 32'(evenIf.data_out), 32'h0);
        checkOutput("abort_valid", 32'(evenIf.valid), 32'h0);
        checkOutput("abort_busy", 32'(evenIf.busy), 32'h0);
        checkOutput("abort_flags", 32'({evenIf.parity_err, evenIf.frame_err}), 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) strobe(1'b1, 1);
        checkOutput("abort_no_valid", 32'(validCnt - v0), 32'h0);
        checkOutput("abort_data_after", 32'(evenIf.data_out), 32'h0);
        applyStimulus(8'h12, 1'b0, 1'b1, 1);
        checkOutput("after_abort_valid", 32'(evenIf.valid), 32'h1);
        checkOutput("after_abort_data", 32'(evenIf.data_out), 32'h12);
        checkOutput("after_abort_perr", 32'(evenIf.parity_err), 32'h0);

        // Back-to-back frames with no idle bit between them.
        applyStimulus(8'h01, 1'b1, 1'b1, 1);
        c1 = cycle;
        checkOutput("b2b_first_valid", 32'(evenIf.valid), 32'h1);
        checkOutput("b2b_first_data", 32'(evenIf.data_out), 32'h01);
        applyStimulus(8'h80, 1'b1, 1'b1, 1);
        c2 = cycle;
        checkOutput("b2b_second_valid", 32'(evenIf.valid), 32'h1);
        checkOutput("b2b_second_data", 32'(evenIf.data_out), 32'h80);
        checkOutput("b2b_second_perr", 32'(evenIf.parity_err), 32'h0);
        checkOutput("b2b_spacing", 32'(c2 - c1), 32'd11);

`ifdef PARITY_RX_ERR_CNT_EN
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int n = 0; n < 300; n++) applyStimulus(8'h07, 1'b0, 1'b1, 1);
        checkOutput("errcnt_sat", 32'(evenIf.err_count), 32'd255);
        applyStimulus(8'h3C, 1'b1, 1'b0, 1);
        checkOutput("errcnt_hold", 32'(evenIf.err_count), 32'd255);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checkOutput("errcnt_reset", 32'(evenIf.err_count), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/parity_frame_rx.md
Name: parity_frame_rx

Overview:
Serial receive end of the byte-plus-parity link. The transmit side registers a byte and emits its XOR-reduction parity bit. This block samples a serial line once per bit strobe and deframes start / DATA_W data bits (LSB first) / parity / stop. It checks parity and stop, then presents the recovered word with a one-cycle valid pulse and error flags to downstream logic.

Parameters:
DATA_W, 8, number of data bits per frame (legal range 4..16)
ODD_PARITY, 0, 0 = even parity (parity bit = ^data, matching the transmit side); 1 = odd parity (parity bit = ~^data)

Ports:
clk  input  1  system clock; all logic on the rising edge
reset  input  1  synchronous, active-high reset
en  input  1  bit strobe; serial_in is sampled only on cycles with en=1
serial_in  input  1  serial line; idles high
data_out  output  DATA_W  last received word; held until the next frame completes
valid  output  1  single-clk pulse when a frame completes
parity_err  output  1  parity mismatch for the frame in data_out; held with data_out
frame_err  output  1  stop bit sampled as 0 for the frame in data_out; held with data_out
busy  output  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Reset values: data_out=0, valid=0, parity_err=0, frame_err=0, busy=0, state=IDLE, bit counter=0, shift register=0.
- Reset has priority over all other inputs. Reset mid-frame aborts the frame: no valid pulse, and data_out and flags clear to 0.
- State changes only on en=1 cycles. With en=0, the state, counter and shift register hold.
- The valid pulse is cleared on the next clk regardless of en.
- IDLE: en & serial_in=0 -> DATA, counter=0. en & serial_in=1 -> stay in IDLE.
- DATA: each en cycle shifts serial_in into the shift register MSB side (shift right), so the first-received bit ends at bit 0. Counter increments. The en cycle that samples the bit with counter=DATA_W-1 -> PARITY.
- PARITY: en cycle latches the parity bit -> STOP.
- STOP: on the en cycle:
  - data_out <= shift register
  - parity_err <= (^shift_reg ^ parity_bit) != ODD_PARITY
  - frame_err <= ~serial_in
  - valid <= 1
  - -> IDLE
- Frames with errors are still delivered (valid=1); flags qualify them.
- Latency: valid, data_out and the flags update on the clk edge that samples the stop bit, and are visible the following cycle.
- Back-to-back frames: a start bit on the en cycle immediately after the stop is accepted, with no idle bit required.
- busy is high from the clk after start detection through the clk that samples the stop bit, then low.
- en held high continuously is legal: one frame completes every DATA_W+3 cycles.
- Counter width: $clog2(DATA_W), no wrap beyond DATA_W-1.

Optional Feature:
PARITY_RX_ERR_CNT_EN:
- Defined: adds output err_count [7:0]. It increments by 1 on each completed frame with parity_err or frame_err set (a frame with both counts once). It saturates at 255 and resets to 0.
- Undefined: no err_count port and no counter logic. All other behaviour is identical.

Decomposition:
- Package parity_rx_pkg holds:
  - state enum rx_state_t {IDLE, DATA, PARITY, STOP} (2-bit)
  - localparam ERR_CNT_W=8
  - function calc_parity(data, odd) returning the expected parity bit, shared with the transmit side
- One sub-module: parity_rx_shift (DATA_W-bit shift register with clk, reset, shift_en, serial_in, q).
- The FSM, counter and output registers stay in parity_frame_rx.

Test Plan:
- Even mode, en=1 continuously, frame 0 / A5 LSB-first / parity 0 / stop 1 -> one valid pulse, data_out=8'hA5, parity_err=0, frame_err=0, busy low after the stop.
- Frame 8'h07 with parity bit 0 -> data_out=8'h07, parity_err=1. Repeat with ODD_PARITY=1 and parity bit 0 -> parity_err=0.
- Frame 8'h3C, parity 0, stop sampled 0 -> valid, data_out=8'h3C, frame_err=1, parity_err=0.
- en pulsed every 4th clk, serial_in toggling between strobes, frame 8'h5A -> only strobe samples are used, data_out=8'h5A, exactly one valid pulse lasting 1 clk.
- Reset asserted after 4 data bits of frame 8'hFF, then a clean frame 8'h12 -> no valid for the aborted frame, all outputs 0 during and after reset, next valid gives data_out=8'h12. Back-to-back 8'h01 then 8'h80 with no idle bit -> two valid pulses DATA_W+3 cycles apart.
- With PARITY_RX_ERR_CNT_EN: 300 frames each with a parity error -> err_count reads 255 and stays at 255. Reset -> 0.
